// File: rtl/sprite_pkg.sv
// Slot map, per-slot sprite geometry and animation constants shared by the sprite compositor.
package sprite_pkg;
    localparam int NUM_SPR      = 10;
    localparam int SLOT_BUL0    = 0;
    localparam int SLOT_EXP0    = 3;
    localparam int SLOT_SAMUS   = 6;
    localparam int SLOT_MON0    = 7;

    localparam int SAMUS_W      = 32;
    localparam int SAMUS_H      = 48;
    localparam int BIG_W        = 32;
    localparam int BUL_W        = 8;
    localparam int ANIM_DIV     = 6;
    localparam int EXP_FRAMES   = 5;
    localparam int SAMUS_FRAMES = 4;

    typedef logic [2:0] frame_t;

    localparam frame_t JUMP_FRAME = 3'd4;

    function automatic logic [10:0] spr_w(input int slot);
        if (slot >= SLOT_BUL0 && slot < SLOT_EXP0) return 11'(BUL_W);
        else if (slot == SLOT_SAMUS)               return 11'(SAMUS_W);
        else if (slot >= SLOT_MON0)                return 11'(BIG_W);
        else                                       return 11'(BIG_W);
    endfunction

    function automatic logic [10:0] spr_h(input int slot);
        if (slot >= SLOT_BUL0 && slot < SLOT_EXP0) return 11'(BUL_W);
        else if (slot == SLOT_SAMUS)               return 11'(SAMUS_H);
        else                                       return 11'(BIG_W);
    endfunction
endpackage

// File: rtl/anim_counter.sv
// Per-frame animation counter: a frame divider feeding either a wrapping or a saturating frame index.
module anim_counter
    import sprite_pkg::*;
#(
    parameter int DIV = ANIM_DIV
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   tick,
    input  logic   en,
    input  logic   sat,
    input  frame_t last,
    output frame_t frame
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q;
    logic          en_q;
    logic          step;

    assign step = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            en_q  <= 1'b0;
            frame <= '0;
        end else if (tick) begin
            en_q  <= en;
            div_q <= step ? '0 : div_q + 1'b1;
            if (!en) begin
                frame <= '0;
            end else if (sat && !en_q) begin
                // a fresh one-shot restarts its timing from this frame
                frame <= '0;
                div_q <= '0;
            end else if (step) begin
                if (frame != last) frame <= frame + 1'b1;
                else if (!sat)     frame <= '0;
            end
        end
    end
endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite hit test: frame-latched sprite state, 2-stage hit/priority pipeline, animation frames.
module sprite_compositor
    import sprite_pkg::*;
(
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [9:0]            draw_x,
    input  logic [9:0]            draw_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [10*NUM_SPR-1:0] spr_x,
    input  logic [10*NUM_SPR-1:0] spr_y,
    input  logic                  samus_dir,
    input  logic                  samus_walk,
    input  logic                  samus_jump,
    output logic                  hit_valid,
    output logic [3:0]            hit_id,
    output logic [5:0]            hit_lx,
    output logic [5:0]            hit_ly,
    output logic                  hit_mirror,
    output frame_t                hit_frame
);
    logic [NUM_SPR-1:0]      en_sh;
    logic [NUM_SPR-1:0][9:0] x_sh;
    logic [NUM_SPR-1:0][9:0] y_sh;
    logic                    dir_sh;
    logic                    jump_sh;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_sh   <= '0;
            x_sh    <= '0;
            y_sh    <= '0;
            dir_sh  <= 1'b0;
            jump_sh <= 1'b0;
        end else if (frame_start) begin
            en_sh   <= spr_en;
            x_sh    <= spr_x;
            y_sh    <= spr_y;
            dir_sh  <= samus_dir;
            jump_sh <= samus_jump;
        end
    end

    frame_t samus_frame;
    frame_t exp_frame [3];

    anim_counter #(.DIV(ANIM_DIV)) u_samus_anim (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .tick  (frame_start),
        .en    (samus_walk),
        .sat   (1'b0),
        .last  (frame_t'(SAMUS_FRAMES - 1)),
        .frame (samus_frame)
    );

    for (genvar k = 0; k < 3; k++) begin : g_exp_anim
        anim_counter #(.DIV(ANIM_DIV)) u_exp_anim (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .tick  (frame_start),
            .en    (spr_en[SLOT_EXP0+k]),
            .sat   (1'b1),
            .last  (frame_t'(EXP_FRAMES - 1)),
            .frame (exp_frame[k])
        );
    end

    // ---- stage 1: per-slot offset and bounds test ----
    logic signed [10:0] dx_c [NUM_SPR];
    logic signed [10:0] dy_c [NUM_SPR];
    logic [NUM_SPR-1:0] hit_c;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            dx_c[i]  = $signed({1'b0, draw_x} - {1'b0, x_sh[i]});
            dy_c[i]  = $signed({1'b0, draw_y} - {1'b0, y_sh[i]});
            hit_c[i] = en_sh[i] & pix_valid & ~dx_c[i][10] & ~dy_c[i][10]
                     & ($unsigned(dx_c[i]) < spr_w(i)) & ($unsigned(dy_c[i]) < spr_h(i));
        end
    end

    logic [NUM_SPR-1:0]      hit_p1;
    logic                    vld_p1;
    logic [NUM_SPR-1:0][5:0] dx_p1;
    logic [NUM_SPR-1:0][5:0] dy_p1;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hit_p1 <= '0;
            vld_p1 <= 1'b0;
            dx_p1  <= '0;
            dy_p1  <= '0;
        end else begin
            hit_p1 <= hit_c;
            vld_p1 <= |hit_c;
            for (int i = 0; i < NUM_SPR; i++) begin
                dx_p1[i] <= dx_c[i][5:0];
                dy_p1[i] <= dy_c[i][5:0];
            end
        end
    end

    // ---- stage 2: priority select, mirroring and frame lookup ----
    logic [3:0] win_c;
    logic       mirror_c;
    logic [5:0] lx_c;
    frame_t     frame_c;
    frame_t     slot_frame [NUM_SPR];

    always_comb begin
        for (int i = 0; i < NUM_SPR; i++) slot_frame[i] = '0;
        for (int k = 0; k < 3; k++) slot_frame[SLOT_EXP0+k] = exp_frame[k];
        slot_frame[SLOT_SAMUS] = jump_sh ? JUMP_FRAME : samus_frame;

        win_c = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_p1[i]) win_c = 4'(i);
        end
        mirror_c = vld_p1 & dir_sh & (win_c == 4'(SLOT_SAMUS));
        lx_c     = mirror_c ? 6'(SAMUS_W - 1) - dx_p1[win_c] : dx_p1[win_c];
        frame_c  = slot_frame[win_c];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n || !vld_p1) begin
            hit_valid  <= 1'b0;
            hit_id     <= '0;
            hit_lx     <= '0;
            hit_ly     <= '0;
            hit_mirror <= 1'b0;
            hit_frame  <= '0;
        end else begin
            hit_valid  <= 1'b1;
            hit_id     <= win_c;
            hit_lx     <= lx_c;
            hit_ly     <= dy_p1[win_c];
            hit_mirror <= mirror_c;
            hit_frame  <= frame_c;
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: frame-latched shadow model, geometry/priority model, animation expectations.
module tb_sprite_compositor;
    logic         clk_clk = 1'b0;
    logic         reset_reset_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [9:0]   draw_x = '0;
    logic [9:0]   draw_y = '0;
    logic [9:0]   spr_en = '0;
    logic [99:0]  spr_x = '0;
    logic [99:0]  spr_y = '0;
    logic         samus_dir = 1'b0;
    logic         samus_walk = 1'b0;
    logic         samus_jump = 1'b0;
    logic         hit_valid;
    logic [3:0]   hit_id;
    logic [5:0]   hit_lx;
    logic [5:0]   hit_ly;
    logic         hit_mirror;
    logic [2:0]   hit_frame;

    sprite_compositor dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .spr_en        (spr_en),
        .spr_x         (spr_x),
        .spr_y         (spr_y),
        .samus_dir     (samus_dir),
        .samus_walk    (samus_walk),
        .samus_jump    (samus_jump),
        .hit_valid     (hit_valid),
        .hit_id        (hit_id),
        .hit_lx        (hit_lx),
        .hit_ly        (hit_ly),
        .hit_mirror    (hit_mirror),
        .hit_frame     (hit_frame)
    );

    always #5 clk_clk = ~clk_clk;

    wire [20:0] obs = {hit_valid, hit_id, hit_lx, hit_ly, hit_mirror, hit_frame};

    // model of the frame-latched sprite state
    logic [9:0]  sh_en;
    logic [9:0]  sh_x [10];
    logic [9:0]  sh_y [10];
    logic        sh_dir;
    logic [2:0]  exp_frm [10];
    logic [20:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [20:0] model(input logic [9:0] x, input logic [9:0] y, input logic v);
        logic [20:0] r;
        int w, h, dx, dy, lx;
        logic mir;
        r = '0;
        for (int i = 9; i >= 0; i--) begin
            w  = (i < 3) ? 8 : 32;
            h  = (i < 3) ? 8 : ((i == 6) ? 48 : 32);
            dx = int'(x) - int'(sh_x[i]);
            dy = int'(y) - int'(sh_y[i]);
            if (v && sh_en[i] && dx >= 0 && dy >= 0 && dx < w && dy < h) begin
                mir = (i == 6) && sh_dir;
                lx  = mir ? (w - 1 - dx) : dx;
                r   = {1'b1, 4'(i), 6'(lx), 6'(dy), mir, exp_frm[i]};
            end
        end
        return r;
    endfunction

    task automatic latch_model;
        sh_en  = spr_en;
        sh_dir = samus_dir;
        for (int i = 0; i < 10; i++) begin
            sh_x[i] = spr_x[10*i +: 10];
            sh_y[i] = spr_y[10*i +: 10];
        end
    endtask

    task automatic clear_model;
        sh_en  = '0;
        sh_dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sh_x[i] = '0;
            sh_y[i] = '0;
            exp_frm[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic set_spr(input int i, input logic en, input int x, input int y);
        spr_en[i] = en;
        spr_x[10*i +: 10] = 10'(x);
        spr_y[10*i +: 10] = 10'(y);
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        pix_valid = v;
        exp_q.push_back(model(10'(x), 10'(y), v));
    endtask

    task automatic drive_pix(input int x, input int y, input logic v);
        @(negedge clk_clk);
        set_pix(x, y, v);
    endtask

    task automatic do_frame;
        @(negedge clk_clk);
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk_clk);
        frame_start = 1'b0;
        latch_model();
    endtask

    task automatic apply_reset;
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        pix_valid     = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        clear_model();
    endtask

    task automatic test_reset;
        logic [20:0] e;
        clear_model();
        reset_reset_n = 1'b0;
        set_spr(6, 1'b1, 100, 200);
        draw_x = 10'd100; draw_y = 10'd200; pix_valid = 1'b1;
        repeat (2) @(negedge clk_clk);
        n_vec++;
        if (obs !== 21'h0) begin n_err++; $display("FAIL reset_idle got=%h exp=%h", obs, 21'h0); end
        reset_reset_n = 1'b1;
        do_frame();
        drive_pix(100, 200, 1'b1);
        repeat (2) @(negedge clk_clk);
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_prehit got=%h exp=%h", obs, e); end
        #2 reset_reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 21'h0) begin n_err++; $display("FAIL reset_async got=%h exp=%h", obs, 21'h0); end
        clear_model();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        drive_pix(100, 200, 1'b1);
        repeat (2) @(negedge clk_clk);
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_noshadow got=%h exp=%h", obs, e); end
        do_frame();
        drive_pix(100, 200, 1'b1);
        repeat (2) @(negedge clk_clk);
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e || obs !== {1'b1, 4'd6, 6'd0, 6'd0, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL reset_reappear got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_priority;
        logic [20:0] e;
        int px [4] = '{112, 100, 118, 117};
        int py [4] = '{212, 200, 212, 212};
        spr_en = '0; samus_dir = 1'b0; samus_walk = 1'b0; samus_jump = 1'b0;
        apply_reset();
        set_spr(0, 1'b1, 110, 210);
        set_spr(6, 1'b1, 100, 200);
        do_frame();
        for (int i = 0; i < 4; i++) begin
            drive_pix(px[i], py[i], 1'b1);
            repeat (2) @(negedge clk_clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL priority[%0d] got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_mirror;
        logic [20:0] e;
        int px [6] = '{100, 131, 132, 100, 100, 400};
        int py [6] = '{200, 247, 200, 200, 200, 200};
        spr_en = '0; samus_dir = 1'b1;
        set_spr(6, 1'b1, 100, 200);
        do_frame();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) set_spr(6, 1'b1, 400, 200);
            if (i == 4) do_frame();
            drive_pix(px[i], py[i], 1'b1);
            repeat (2) @(negedge clk_clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL mirror[%0d] got=%h exp=%h", i, obs, e); end
        end
        samus_dir = 1'b0;
    endtask

    task automatic test_boundary;
        logic [20:0] e;
        int   px [7] = '{629, 630, 639, 0, 635, 635, 635};
        int   py [7] = '{50, 50, 50, 50, 50, 81, 82};
        logic pv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        spr_en = '0;
        set_spr(7, 1'b1, 630, 50);
        do_frame();
        for (int i = 0; i < 7; i++) begin
            drive_pix(px[i], py[i], pv[i]);
            repeat (2) @(negedge clk_clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL boundary[%0d] got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [20:0] e;
        spr_en = '0; samus_dir = 1'b0;
        apply_reset();
        set_spr(0, 1'b1, 110, 210);
        set_spr(6, 1'b1, 100, 200);
        do_frame();
        set_spr(6, 1'b1, 200, 200);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_clk);
            if (i >= 2) begin
                e = exp_q.pop_front(); n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL stream[%0d] got=%h exp=%h", i, obs, e); end
            end
            if (i < 12) begin
                set_pix(104 + i, 212, 1'b1);
            end else if (i == 12) begin
                frame_start = 1'b1;
                set_pix(100, 212, 1'b1);
                latch_model();
            end else if (i == 13) begin
                frame_start = 1'b0;
                set_pix(100, 212, 1'b1);
            end else if (i == 14) begin
                set_pix(200, 212, 1'b1);
            end else begin
                set_pix(203, 215, 1'b1);
            end
        end
        repeat (2) begin
            @(negedge clk_clk);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL stream_drain got=%h exp=%h", obs, e); end
        end
    endtask

    task automatic test_samus_anim;
        logic [20:0] e;
        spr_en = '0; samus_dir = 1'b0;
        apply_reset();
        set_spr(6, 1'b1, 100, 200);
        for (int n = 1; n <= 32; n++) begin
            samus_walk = (n <= 31);
            samus_jump = (n >= 26 && n <= 30);
            do_frame();
            if (samus_jump)      exp_frm[6] = 3'd4;
            else if (samus_walk) exp_frm[6] = 3'((n / 6) % 4);
            else                 exp_frm[6] = 3'd0;
            if (n == 5 || n == 6 || n == 12 || n == 24 || n == 26 || n == 30 || n == 31 || n == 32) begin
                drive_pix(110, 220, 1'b1);
                repeat (2) @(negedge clk_clk);
                e = exp_q.pop_front(); n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL samus_anim[n=%0d] got=%h exp=%h", n, obs, e); end
            end
        end
        samus_walk = 1'b0; samus_jump = 1'b0;
    endtask

    task automatic test_explosion;
        logic [20:0] e;
        int fr;
        spr_en = '0;
        apply_reset();
        for (int n = 1; n <= 40; n++) begin
            set_spr(3, (n != 33), 300, 100);
            do_frame();
            fr = (n <= 32) ? (n - 1) / 6 : (n - 34) / 6;
            exp_frm[3] = 3'((fr > 4) ? 4 : ((fr < 0) ? 0 : fr));
            if (n == 1 || n == 6 || n == 7 || n == 13 || n == 19 || n == 25 || n == 31 ||
                n == 33 || n == 34 || n == 39 || n == 40) begin
                drive_pix(305, 110, 1'b1);
                repeat (2) @(negedge clk_clk);
                e = exp_q.pop_front(); n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL explosion[n=%0d] got=%h exp=%h", n, obs, e); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_priority();
        test_mirror();
        test_boundary();
        test_back_to_back();
        test_samus_anim();
        test_explosion();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream consumer of the Nios system's sprite exports: samus, monster1-3, bullet1-3 and explosion1-3 x/y/en, plus samus_dir/walk/jump.
- Latches all sprite state once per frame into shadow registers.
- Hit-tests each VGA pixel against every sprite in a 2-stage pipeline and outputs the winning sprite's ID, local texel offset, mirror flag and animation frame.
- Feeds the sprite ROM address generator and colour mapper.

Parameters:
NUM_SPR, 10, sprite slots; priority order 0 (highest) to 9: 0-2 bullet1-3, 3-5 explosion1-3, 6 samus, 7-9 monster1-3
SAMUS_W, 32, samus width in pixels
SAMUS_H, 48, samus height in pixels
BIG_W, 32, monster/explosion width and height
BUL_W, 8, bullet width and height
ANIM_DIV, 6, frames per animation step
EXP_FRAMES, 5, explosion frame count

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  draw_x/draw_y are in the active area
draw_x  in  10  current pixel column
draw_y  in  10  current pixel row
spr_en  in  NUM_SPR  per-slot enable
spr_x  in  10*NUM_SPR  packed top-left x; slot i at [10i+9:10i]
spr_y  in  10*NUM_SPR  packed top-left y
samus_dir  in  1  1 = facing left
samus_walk  in  1  walking
samus_jump  in  1  airborne
hit_valid  out  1  a sprite covers the pixel
hit_id  out  4  winning slot index
hit_lx  out  6  pixel x offset inside the sprite (mirrored if applicable)
hit_ly  out  6  pixel y offset inside the sprite
hit_mirror  out  1  texel was mirrored
hit_frame  out  3  animation frame for the winning sprite

Behaviour:
- Reset: all outputs 0, shadow registers 0, animation counters 0. Reset is asynchronous and may arrive mid-frame; sprites reappear only after the next frame_start.
- Shadow latch:
  - On the frame_start cycle, capture spr_en, spr_x, spr_y, samus_dir, samus_walk and samus_jump.
  - Input changes outside frame_start have no effect.
  - A pixel presented in the same cycle as frame_start uses the old shadow; the new shadow applies from the next cycle.
- Stage 1 (registered):
  - For each slot i: dx = {1'b0,draw_x} - {1'b0,sx_i}, dy likewise, both 11-bit two's complement.
  - hit_i = en_i & pix_valid & !dx[10] & !dy[10] & dx < W_i & dy < H_i.
  - No wrap-around: draw_x < sx gives no hit; a sprite at x=630, W=32 covers columns 630-639 only.
- Stage 2 (registered):
  - Fixed-priority encode; the lowest asserted index wins.
  - hit_lx = dx[5:0], or W_i-1-dx when slot 6 and samus_dir=1 (then hit_mirror=1).
  - hit_ly = dy[5:0].
- Latency: exactly 2 cycles from draw_x/draw_y/pix_valid to outputs. With no hit, hit_valid=0 and all other outputs are 0.
- Samus animation (updates on frame_start):
  - frame_div counts 0..ANIM_DIV-1, wraps to 0, and emits a step on the wrap.
  - walk frame: 0..3 advancing on each step while the latched walk=1; forced to 0 when walk=0.
  - jump=1 forces a reported frame of 4 without changing the walk frame.
- Explosion slots 3-5 (per slot):
  - On the latched en 0->1 edge, frame=0 and the divider clears.
  - Frame advances on each step up to EXP_FRAMES-1, then holds.
  - en=0 clears frame to 0.
- Other slots: hit_frame=0.

Decomposition:
- Package sprite_pkg: slot index constants (SLOT_BUL0, SLOT_EXP0, SLOT_SAMUS, SLOT_MON0), the per-slot width/height constant function, and the 3-bit frame typedef.
- One sub-module anim_counter (divider plus saturating or wrapping frame counter, with mode input): one instance for samus, three for explosions.

Test Plan:
- Reset mid-frame with samus enabled at (100,200) -> outputs 0; pixel (100,200) gives hit_valid=0 until the next frame_start, then hit_id=6, lx=0, ly=0 two cycles after the pixel.
- Bullet1 at (110,210) overlapping samus at (100,200); pixel (112,212) -> hit_id=0, lx=2, ly=2 (priority).
- samus_dir=1, W=32, pixel (100,200) -> hit_lx=31, hit_mirror=1. Change spr_x mid-frame -> no effect until frame_start.
- Monster1 at x=630; pixels 629, 630, 639 -> no hit, hit lx=0, hit lx=9. draw_x=0 -> no hit (no wrap).
- samus_walk=1, ANIM_DIV=6 -> frame 1 after 6 frame_starts, 0 again after 24; jump=1 -> frame 4.
- Explosion1 enabled -> frames 0,1,2,3,4 at 6-frame intervals, holds 4; en dropped -> 0.
